// File: rtl/nand_unit_scheduler.sv
// rtl/nand_unit_scheduler.sv - round-robin scheduler sharing one NAND unit between two requesters
// Optional grant/timeout statistics counters are enabled by defining NAND_SCHED_STATS_EN.
module nand_unit_scheduler #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
`ifdef NAND_SCHED_STATS_EN
    ,
    parameter int STAT_W  = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_err,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_err,
    input  logic             rsp1_ready,
    output logic             unit_start,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    input  logic             unit_done,
    input  logic [WIDTH-1:0] unit_res,
    output logic             busy
`ifdef NAND_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_grants0,
    output logic [STAT_W-1:0] stat_grants1,
    output logic [STAT_W-1:0] stat_timeouts
`endif
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_next;
    logic            last, tag;
    logic [TW-1:0]   timer;
    logic [WIDTH-1:0] rsp_data_q;
    logic            rsp_err_q;
    logic            grant_any, grant_sel, rsp_fire, timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        grant_any   = req0_valid | req1_valid;
        // On a tie the requester not served last wins; a lone requester always wins.
        grant_sel   = (req0_valid && req1_valid) ? ~last : req1_valid;
        timeout_hit = (state == WAIT) && !unit_done && (timer == TIMER_LAST);
        rsp_fire    = (state == RESP) && (tag ? rsp1_ready : rsp0_ready);
        state_next  = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req0_ready = ~grant_sel;
                    req1_ready = grant_sel;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    if (unit_done || timer == TIMER_LAST) state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= 1'b1;
            tag        <= 1'b0;
            timer      <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        tag    <= grant_sel;
                        unit_a <= grant_sel ? req1_a : req0_a;
                        unit_b <= grant_sel ? req1_b : req0_b;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (unit_done) begin
                        rsp_data_q <= unit_res;
                        rsp_err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: if (rsp_fire) last <= tag;
                default: ;
            endcase
        end
    end

    // Response registers are only written in WAIT, so a late done cannot disturb a held response.
    assign unit_start = (state == ISSUE);
    assign busy       = (state != IDLE);
    assign rsp0_valid = (state == RESP) && !tag;
    assign rsp1_valid = (state == RESP) && tag;
    assign rsp0_data  = rsp_data_q;
    assign rsp1_data  = rsp_data_q;
    assign rsp0_err   = rsp_err_q;
    assign rsp1_err   = rsp_err_q;

`ifdef NAND_SCHED_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants0  <= '0;
            stat_grants1  <= '0;
            stat_timeouts <= '0;
        end else begin
            if (req0_ready && stat_grants0 != STAT_MAX)   stat_grants0  <= stat_grants0 + 1'b1;
            if (req1_ready && stat_grants1 != STAT_MAX)   stat_grants1  <= stat_grants1 + 1'b1;
            if (timeout_hit && stat_timeouts != STAT_MAX) stat_timeouts <= stat_timeouts + 1'b1;
        end
    end
`else
    // Grant and timeout events are not counted in this build.
`endif

endmodule

// File: tb/tb_nand_unit_scheduler.sv
// tb/tb_nand_unit_scheduler.sv - randomized scoreboard bench for nand_unit_scheduler
module tb_nand_unit_scheduler;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_ready, req1_ready;
    logic             rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [WIDTH-1:0] rsp0_data, rsp1_data;
    logic             rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic             unit_start, unit_done = 1'b0, busy;
    logic [WIDTH-1:0] unit_a, unit_b, unit_res = '0;
`ifdef NAND_SCHED_STATS_EN
    logic [7:0]       stat_grants0, stat_grants1, stat_timeouts;
`endif

    nand_unit_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready),
        .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done), .unit_res(unit_res), .busy(busy)
`ifdef NAND_SCHED_STATS_EN
        , .stat_grants0(stat_grants0), .stat_grants1(stat_grants1), .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit               tag;
        logic [WIDTH-1:0] data;
        bit               err;
        int               cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    bit m_last = 1'b1;
    int m_g0 = 0, m_g1 = 0, m_to = 0;
    bit resp_en = 1'b1;
    bit bp_en = 1'b0;
    bit hold1 = 1'b0;
    int unit_delay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requesters drain responses, optionally with random backpressure.
    always @(posedge clk) begin
        #1;
        rsp0_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        rsp1_ready = !hold1 && (bp_en ? ($urandom_range(0, 1) == 1) : 1'b1);
    end

    // Behavioural NAND unit: answers unit_delay WAIT cycles after the start pulse.
    initial begin : responder
        int d;
        forever begin
            @(negedge clk);
            if (unit_start && resp_en) begin
                d = unit_delay;
                repeat (d + 1) @(posedge clk);
                #1;
                unit_done = 1'b1;
                unit_res  = ~(unit_a & unit_b);
                @(posedge clk);
                #1;
                unit_done = 1'b0;
                unit_res  = WIDTH'($urandom);
            end
        end
    end

    initial begin : monitor
        bit prev_valid, held, vt, er, rdy, he;
        logic [WIDTH-1:0] d, hd;
        exp_t e;
        prev_valid = 0; held = 0; he = 0; hd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0;
                held = 0;
                continue;
            end
            if (busy) chk("ready_while_busy", {req1_ready, req0_ready}, 0);
            chk("dual_rsp_valid", rsp0_valid & rsp1_valid, 0);
            if (rsp0_valid || rsp1_valid) begin
                vt  = rsp1_valid;
                d   = vt ? rsp1_data : rsp0_data;
                er  = vt ? rsp1_err : rsp0_err;
                rdy = vt ? rsp1_ready : rsp0_ready;
                if (held) begin
                    chk("rsp_data_stable", d, hd);
                    chk("rsp_err_stable", er, he);
                end
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", sb.size(), 1);
                end else begin
                    e = sb[0];
                    if (!prev_valid) chk("rsp_latency", cyc, e.cyc);
                    if (rdy) begin
                        chk("rsp_tag", vt, e.tag);
                        chk("rsp_data", d, e.data);
                        chk("rsp_err", er, e.err);
                        void'(sb.pop_front());
                    end
                end
                held = !rdy;
                hd = d;
                he = er;
                prev_valid = !rdy;
            end else begin
                prev_valid = 0;
                held = 0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_last = 1'b1;
        m_g0 = 0; m_g1 = 0; m_to = 0;
        sb.delete();
    endtask

    task automatic issue_op(input bit v0, input bit v1, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                            input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1, input int delay);
        exp_t e;
        bit g;
        int n;
        @(posedge clk);
        #1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        unit_delay = delay;
        req0_valid = v0;
        req1_valid = v1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req0_ready || req1_ready) && n < 50);
        g = (v0 && v1) ? !m_last : v1;
        chk("grant_sel", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
        if (req0_ready || req1_ready) begin
            e.tag  = g;
            e.err  = (delay >= TIMEOUT);
            e.data = e.err ? '0 : ~(g ? (a1 & b1) : (a0 & b0));
            e.cyc  = cyc + (e.err ? TIMEOUT + 2 : delay + 3);
            sb.push_back(e);
            m_last = g;
            if (g) m_g1++; else m_g0++;
            if (e.err) m_to++;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

`ifdef NAND_SCHED_STATS_EN
    task automatic chk_stats(input string tag);
        chk({tag, "_grants0"}, stat_grants0, (m_g0 > 255) ? 255 : m_g0);
        chk({tag, "_grants1"}, stat_grants1, (m_g1 > 255) ? 255 : m_g1);
        chk({tag, "_timeouts"}, stat_timeouts, (m_to > 255) ? 255 : m_to);
    endtask
`endif

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int pat, r, dly, n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_start", unit_start, 0);
        chk("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("reset_err", {rsp1_err, rsp0_err}, 0);
        chk("reset_data", rsp0_data, 0);
        chk("reset_unit_ab", {unit_a, unit_b}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic NAND: F0 nand 3C
        issue_op(1, 0, 8'hF0, 8'h3C, 8'h00, 8'h00, 0);
        drain();

        // Tie from a fresh reset alternates 0,1,0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue_op(1, 1, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), i);
            drain();
        end

        // Unit never answers within the window; also the last in-window cycle
        issue_op(0, 1, 8'hAA, 8'h55, 8'h12, 8'h34, TIMEOUT + 1);
        drain();
        issue_op(1, 0, 8'h0F, 8'hFF, 8'h00, 8'h00, TIMEOUT - 1);
        drain();

        // Held response under backpressure while the other requester waits
        hold1 = 1'b1;
        issue_op(0, 1, 8'h00, 8'h00, 8'h5A, 8'hC3, 1);
        req0_valid = 1'b1;
        repeat (13) begin
            @(negedge clk);
            chk("hold_req0_ready", req0_ready, 0);
            chk("hold_busy", busy, 1);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0;
        hold1 = 1'b0;
        drain();

        // Reset while waiting on the unit, then a stray done
        resp_en = 1'b0;
        @(posedge clk);
        #1 req0_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req0_ready && n < 20);
        chk("abort_grant", req0_ready, 1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        unit_done = 1'b1;
        unit_res  = 8'hAA;
        @(posedge clk);
        #1 unit_done = 1'b0;
        @(negedge clk);
        chk("abort_unit_ab", {unit_a, unit_b}, 0);
        chk("abort_data", {rsp1_data, rsp0_data}, 0);
        repeat (20) begin
            chk("abort_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
            chk("abort_busy", busy, 0);
            chk("abort_start", unit_start, 0);
            @(negedge clk);
        end
        resp_en = 1'b1;
        m_last = 1'b1;
        m_g0 = 0; m_g1 = 0; m_to = 0;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            pat = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            if (r < 6)      dly = $urandom_range(0, 5);
            else if (r < 8) dly = TIMEOUT - 1;
            else            dly = $urandom_range(TIMEOUT, TIMEOUT + 1);
            bp_en = ($urandom_range(0, 1) == 1);
            issue_op(pat != 1, pat != 0, WIDTH'($urandom), WIDTH'($urandom),
                     WIDTH'($urandom), WIDTH'($urandom), dly);
            drain();
        end
        bp_en = 1'b0;

`ifdef NAND_SCHED_STATS_EN
        chk_stats("stats_random");
        do_reset();
        issue_op(1, 0, 8'h01, 8'h02, 8'h00, 8'h00, 0);
        drain();
        issue_op(1, 0, 8'h03, 8'h04, 8'h00, 8'h00, 2);
        drain();
        issue_op(1, 0, 8'h05, 8'h06, 8'h00, 8'h00, TIMEOUT);
        drain();
        chk_stats("stats_small");
        for (int i = 0; i < 300; i++) begin
            issue_op(1, 0, WIDTH'($urandom), WIDTH'($urandom), 8'h00, 8'h00, 0);
            drain();
        end
        chk_stats("stats_sat");
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
